// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule types and constants, plus the 32-bit
// rotate helper that the small-sigma functions are built from.
package sha256_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_BLOCK_WORDS = 16;
  localparam int SHA_MAX_ROUNDS  = 64;

  typedef logic [SHA_WORD_W-1:0] sha_word_t;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } sched_state_t;

  function automatic sha_word_t rotr(input sha_word_t x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma pair: s0 = sigma0(x0), s1 = sigma1(x1).
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  output logic [31:0] s0,
  output logic [31:0] s1
);

  assign s0 = rotr(x0, 5'd7)  ^ rotr(x0, 5'd18) ^ (x0 >> 3'd3);
  assign s1 = rotr(x1, 5'd17) ^ rotr(x1, 5'd19) ^ (x1 >> 4'd10);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads 16 words of a block, then streams
// W0..W(ROUNDS-1) from a sliding 16-word window, expanding one word per shift.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        out_last
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  sched_state_t state_r;
  logic [5:0]   cnt_r;
  sha_word_t    win_r [SHA_BLOCK_WORDS];
  sha_word_t    s0_s;
  sha_word_t    s1_s;
  sha_word_t    next_word_s;

  sha256_small_sigma u_sigma (
    .x0 (win_r[1]),
    .x1 (win_r[14]),
    .s0 (s0_s),
    .s1 (s1_s)
  );

  // Next schedule word entering the top of the window on each shift.
  always_comb begin
    next_word_s = s1_s + win_r[9] + s0_s + win_r[0];
  end

  // State, counter and window; every output below decodes directly from these.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD;
      cnt_r   <= 6'd0;
      for (int i = 0; i < SHA_BLOCK_WORDS; i++) begin
        win_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid) begin
            win_r[cnt_r[3:0]] <= in_word;
            if (cnt_r == 6'd15) begin
              state_r <= EMIT;
              cnt_r   <= 6'd0;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            for (int i = 0; i < SHA_BLOCK_WORDS - 1; i++) begin
              win_r[i] <= win_r[i+1];
            end
            win_r[SHA_BLOCK_WORDS-1] <= next_word_s;
            if (cnt_r == LAST_IDX) begin
              state_r <= LOAD;
              cnt_r   <= 6'd0;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= LOAD;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

  // Outputs are forced to zero outside EMIT so idle values match reset values.
  assign in_ready  = (state_r == LOAD);
  assign out_valid = (state_r == EMIT);
  assign out_word  = out_valid ? win_r[0] : 32'd0;
  assign out_idx   = out_valid ? cnt_r : 6'd0;
  assign out_last  = out_valid && (cnt_r == LAST_IDX);

endmodule
